fp16_mant_normalize: RTL

- Two-stage pipelined normaliser for the float16 multiplier datapath.
- Takes the raw 22-bit significand product (11b x 11b) and counts its leading zeros. It then left-shifts the product into normalised form.
- Emits the leading-zero count as exp_adjust, together with the pre-incremented exponent. The downstream exponent-subtract stage computes exp minus exp_adjust.
- Also produces the 10-bit fraction plus guard/sticky bits for the rounding stage.

---
 rtl/fp16_mant_normalize_if.sv | 39 +++
 rtl/fp16_mant_normalize.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp16_mant_normalize_if.sv
// Handshake and payload bundle between the float16 multiplier product stage,
// the mantissa normaliser and the downstream exponent/rounding stages.
interface fp16_mant_normalize_if #(
  parameter int PROD_W = 22,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 5,
  parameter int ADJ_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [PROD_W-1:0] in_mant;

  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [ADJ_W-1:0]  out_exp_adjust;
  logic [FRAC_W-1:0] out_mant;
  logic              out_guard;
  logic              out_sticky;
  logic              out_zero;

  // The master drives products in and consumes normalised results.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_exp_adjust,
           out_mant, out_guard, out_sticky, out_zero
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_exp_adjust,
           out_mant, out_guard, out_sticky, out_zero
  );

endinterface

// File: rtl/fp16_mant_normalize.sv
// Two-stage significand normaliser: stage 1 captures the product and its
// leading-zero count, stage 2 shifts it and extracts fraction/guard/sticky.
module fp16_mant_normalize #(
  parameter int PROD_W = 22,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 5,
  parameter int ADJ_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp16_mant_normalize_if.slave bus
);

  logic              s1Valid_q;
  logic              s1Sign_q;
  logic [EXP_W-1:0]  s1Exp_q;
  logic [PROD_W-1:0] s1Mant_q;
  logic [ADJ_W-1:0]  s1Lzc_q;
  logic              s1Zero_q;

  logic              s2Valid_q;
  logic              outSign_q;
  logic [EXP_W-1:0]  outExp_q;
  logic [ADJ_W-1:0]  outAdj_q;
  logic [FRAC_W-1:0] outMant_q;
  logic              outGuard_q;
  logic              outSticky_q;
  logic              outZero_q;

  logic              s2Free;
  logic              s1Adv;
  logic              inReady;
  logic              accept;

  logic [ADJ_W-1:0]  lzc_d;
  logic              zero_d;
  logic [PROD_W-1:0] shifted;
  logic [FRAC_W-1:0] outMant_d;
  logic              outGuard_d;
  logic              outSticky_d;

  assign s2Free  = !s2Valid_q || bus.out_ready;
  assign s1Adv   = s1Valid_q && s2Free;
  assign inReady = !s1Valid_q || s2Free;
  assign accept  = bus.in_valid && inReady;

  // Ascending scan so the highest set bit is the last to write the count;
  // an all-zero product leaves the count at 0.
  always_comb begin
    lzc_d = '0;
    for (int i = 0; i < PROD_W; i++) begin
      if (bus.in_mant[i]) begin
        lzc_d = ADJ_W'(PROD_W - 1 - i);
      end
    end
    zero_d = (bus.in_mant == '0);
  end

  always_comb begin
    shifted     = s1Mant_q << s1Lzc_q;
    outMant_d   = '0;
    outGuard_d  = 1'b0;
    outSticky_d = 1'b0;
    if (!s1Zero_q) begin
      outMant_d   = shifted[PROD_W-2 -: FRAC_W];
      outGuard_d  = shifted[PROD_W-2-FRAC_W];
      outSticky_d = |shifted[PROD_W-3-FRAC_W:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q   <= 1'b0;
      s1Sign_q    <= 1'b0;
      s1Exp_q     <= '0;
      s1Mant_q    <= '0;
      s1Lzc_q     <= '0;
      s1Zero_q    <= 1'b0;
      s2Valid_q   <= 1'b0;
      outSign_q   <= 1'b0;
      outExp_q    <= '0;
      outAdj_q    <= '0;
      outMant_q   <= '0;
      outGuard_q  <= 1'b0;
      outSticky_q <= 1'b0;
      outZero_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1Valid_q <= 1'b1;
        s1Sign_q  <= bus.in_sign;
        s1Exp_q   <= bus.in_exp;
        s1Mant_q  <= bus.in_mant;
        s1Lzc_q   <= lzc_d;
        s1Zero_q  <= zero_d;
      end else if (s1Adv) begin
        s1Valid_q <= 1'b0;
      end

      // Output registers only move on advance, so a stalled result holds.
      if (s1Adv) begin
        s2Valid_q   <= 1'b1;
        outSign_q   <= s1Sign_q;
        outExp_q    <= s1Exp_q;
        outAdj_q    <= s1Lzc_q;
        outMant_q   <= outMant_d;
        outGuard_q  <= outGuard_d;
        outSticky_q <= outSticky_d;
        outZero_q   <= s1Zero_q;
      end else if (bus.out_ready) begin
        s2Valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = inReady;
  assign bus.out_valid      = s2Valid_q;
  assign bus.out_sign       = outSign_q;
  assign bus.out_exp        = outExp_q;
  assign bus.out_exp_adjust = outAdj_q;
  assign bus.out_mant       = outMant_q;
  assign bus.out_guard      = outGuard_q;
  assign bus.out_sticky     = outSticky_q;
  assign bus.out_zero       = outZero_q;

endmodule
